// File: rtl/uart_tx_streamer.sv
// Byte-stream UART transmitter (8N1, LSB first) with a small input FIFO.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
//   state  | meaning
//   IDLE   | line high, pops FIFO head when non-empty
//   START  | start bit (low)
//   DATA   | eight data bits, LSB first
//   PARITY | even parity bit (UART_TX_PARITY_EN only)
//   STOP   | stop bit (high)
module uart_tx_streamer #(
  parameter int BAUD_DIV   = 347,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx_o,
  output logic                          tx_oeb,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  state_t           state;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             push;
  logic             pop;
  logic             baud_tc;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // tx_oeb doubles as the "out of reset" flag so in_ready stays low during reset
  assign in_ready = ~tx_oeb & (fifo_level != LVL_FULL);
  assign push     = in_valid & in_ready;
  assign pop      = (state == IDLE) & (fifo_level != '0);
  assign baud_tc  = (baud_cnt == BAUD_LAST);
  assign busy     = (state != IDLE) | (fifo_level != '0);

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
      else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);
    end
  end

  // tx_o is registered from the current state, so the line trails the state by one clock
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      tx_o       <= 1'b1;
      tx_oeb     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_oeb <= 1'b0;
      case (state)
        IDLE: begin
          tx_o     <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift_reg  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
            state      <= START;
          end
        end
        START: begin
          tx_o <= 1'b0;
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          tx_o <= shift_reg[0];
          if (baud_tc) begin
            baud_cnt  <= '0;
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_o <= parity_bit;
          if (baud_tc) begin
            baud_cnt <= '0;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          tx_o <= 1'b1;
          if (baud_tc) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          tx_o  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
